fifo_tx_reader: RTL

Read-side engine for the 8-bit `fifo_flag` buffer. It pops one byte at a time whenever the FIFO reports non-empty, then shifts the byte out on a single serial line as an asynchronous frame: start bit, 8 data bits LSB first, optional parity, and a stop bit. It sits between `fifo_flag` (`d_out`, `empty`, `rd`) and the board-level serial pin. It is the consumer counterpart to whatever logic writes the FIFO.

---
 rtl/fifo_tx_reader.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fifo_tx_reader.sv
// fifo_tx_reader: pops bytes from fifo_flag and sends each as an async serial frame (start, 8 data LSB first, optional even parity, stop); parity enabled by FIFO_TX_PARITY_EN
module fifo_tx_reader #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);
    localparam int CNT_W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE, POP, LOAD, START, DATA,
`ifdef FIFO_TX_PARITY_EN
        PAR,
`endif
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d, rd_q, rd_d, done_q, done_d, wrap;
`ifdef FIFO_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    // next state, with registered outputs derived from the state being entered
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        idx_d   = idx_q;
        shift_d = shift_q;
`ifdef FIFO_TX_PARITY_EN
        par_d   = par_q;
`endif
        wrap    = cnt_q == CNT_MAX;
        cnt_nxt = wrap ? '0 : cnt_q + 1'b1;
        case (state_q)
            IDLE:  state_d = fifo_empty ? IDLE : POP;
            POP:   state_d = LOAD;
            LOAD: begin
                shift_d = fifo_dout;
                idx_d   = '0;
                state_d = START;
`ifdef FIFO_TX_PARITY_EN
                par_d   = ^fifo_dout;
`endif
            end
            START: begin
                cnt_d   = cnt_nxt;
                state_d = wrap ? DATA : START;
            end
            DATA: begin
                cnt_d = cnt_nxt;
                if (wrap) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
`ifdef FIFO_TX_PARITY_EN
                    state_d = idx_q == 3'd7 ? PAR : DATA;
`else
                    state_d = idx_q == 3'd7 ? STOP : DATA;
`endif
                end
            end
`ifdef FIFO_TX_PARITY_EN
            PAR: begin
                cnt_d   = cnt_nxt;
                state_d = wrap ? STOP : PAR;
            end
`endif
            STOP: begin
                cnt_d   = cnt_nxt;
                state_d = wrap ? IDLE : STOP;
            end
            default: state_d = IDLE;
        endcase
        tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
`ifdef FIFO_TX_PARITY_EN
        if (state_d == PAR) tx_d = par_d;
`endif
        rd_d   = state_d == POP;
        done_d = state_d == STOP && cnt_d == CNT_MAX;
    end

    // state and output registers; reset forces the line high at once and drops the frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef FIFO_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
`ifdef FIFO_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx        = tx_q;
    assign fifo_rd   = rd_q;
    assign byte_done = done_q;
    assign busy      = state_q != IDLE;
endmodule
